// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_pkg
// Description : Shared RV32I datapath constants and types. Holds the
//               register-file geometry and the word and register-index
//               types used by decode, execute and writeback.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_pkg;

    localparam int XLEN   = 32;  // width of every architectural register
    localparam int NREGS  = 32;  // number of architectural registers
    localparam int REG_AW = 5;   // register index width, $clog2(NREGS)

    typedef logic [REG_AW-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]   word_t;

endpackage : rv_pkg
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
// Module      : register_file
// Description : RV32I integer register file with 32 x 32-bit registers, two
//               combinational read ports and one write port. The write port
//               commits on the rising clock edge. x0 always reads as zero.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1       clock; all state updates on its rising edge
//   rstN       in   1       asynchronous reset, ACTIVE-HIGH despite the name;
//                           clears every register
//   we         in   1       write enable, sampled on rising edge of clk
//   rs1        in   REG_AW  read-port-1 register index
//   rs2        in   REG_AW  read-port-2 register index
//   rd         in   REG_AW  write register index
//   data_in    in   XLEN    write data
//   data_out1  out  XLEN    contents of regs[rs1] (0 when rs1 == 0)
//   data_out2  out  XLEN    contents of regs[rs2] (0 when rs2 == 0)
// ============================================================================
module register_file
    import rv_pkg::*;
(
    input  logic              clk,
    input  logic              rstN,
    input  logic              we,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic [REG_AW-1:0] rd,
    input  logic [XLEN-1:0]   data_in,
    output logic [XLEN-1:0]   data_out1,
    output logic [XLEN-1:0]   data_out2
);

    // x0 is never stored; the array starts at index 1.
    word_t r_regs [1:NREGS-1];

    // Writes to rd == 0 are dropped here, so the x0 entry can never be
    // addressed in the array. Reset dominates a coincident write.
    always_ff @(posedge clk or posedge rstN) begin
        if (rstN) begin
            for (int i = 1; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (we && (rd != '0)) begin
            r_regs[rd] <= data_in;
        end
    end

    // No write-to-read bypass: a same-cycle write is only visible after the
    // clock edge that commits it.
    assign data_out1 = (rs1 == '0) ? '0 : r_regs[rs1];
    assign data_out2 = (rs2 == '0) ? '0 : r_regs[rs2];

endmodule : register_file
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_file
// Description : Directed self-checking bench for register_file. Expected
//               values come from hand-computed constants and a small
//               reference array of the architectural register state.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_register_file;

    logic        clk;
    logic        rstN;
    logic        we;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] data_in;
    logic [31:0] data_out1;
    logic [31:0] data_out2;

    logic        run_clk;
    int          n_tests;
    int          n_fail;
    logic [31:0] model [0:31];
    logic [31:0] sum;

    register_file u_dut (
        .clk       (clk),
        .rstN      (rstN),
        .we        (we),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .data_in   (data_in),
        .data_out1 (data_out1),
        .data_out2 (data_out2)
    );

    // Clock is held low until the initial reset phase is over, so the first
    // reset window sees no clock edge at all.
    initial begin
        clk = 1'b0;
        wait (run_clk);
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fill_val(input int x);
        logic [31:0] v;
        v = 32'(x + 4069);
        return v * v;
    endfunction

    initial begin
        n_tests = 0;
        n_fail  = 0;
        run_clk = 1'b0;
        we      = 1'b0;
        rs1     = '0;
        rs2     = '0;
        rd      = '0;
        data_in = '0;
        for (int i = 0; i < 32; i++) model[i] = '0;

        // ---------------- Reset with no clock edge ----------------
        rstN = 1'b1;
        for (int i = 0; i < 32; i++) begin
            rs1 = 5'(i);
            rs2 = 5'(31 - i);
            #1;
            check($sformatf("reset_rd1_x%0d", i), data_out1, 32'd0);
            check($sformatf("reset_rd2_x%0d", 31 - i), data_out2, 32'd0);
        end
        rstN    = 1'b0;
        #1;
        run_clk = 1'b1;
        @(negedge clk);

        // ---------------- Fill x1..x31 ----------------
        for (int x = 1; x < 32; x++) begin
            we      = 1'b1;
            rd      = 5'(x);
            data_in = fill_val(x);
            model[x] = fill_val(x);
            @(negedge clk);
        end
        we = 1'b0;
        rs1 = 5'd1;
        rs2 = 5'd31;
        #1;
        check("fill_example_r1", data_out1, 32'd16564900);
        check("fill_example_r31", data_out2, 32'd16810000);
        for (int x = 1; x < 32; x++) begin
            rs1 = 5'(x);
            rs2 = 5'(x);
            #1;
            check($sformatf("fill_rd1_x%0d", x), data_out1, model[x]);
            check($sformatf("fill_same_idx_x%0d", x), data_out2, model[x]);
        end

        // ---------------- x0 write is discarded ----------------
        @(negedge clk);
        we      = 1'b1;
        rd      = 5'd0;
        data_in = 32'd16556761;
        @(negedge clk);
        we  = 1'b0;
        rs1 = 5'd0;
        rs2 = 5'd0;
        #1;
        check("x0_rd1", data_out1, 32'd0);
        check("x0_rd2", data_out2, 32'd0);

        // ---------------- Dual read and writeback ----------------
        for (int x = 1; x <= 5; x++) begin
            @(negedge clk);
            rs1 = 5'(x);
            rs2 = 5'(31 - x);
            #1;
            check($sformatf("dual_rd1_x%0d", x), data_out1, model[x]);
            check($sformatf("dual_rd2_x%0d", 31 - x), data_out2, model[31 - x]);
            sum     = data_out1 + data_out2;
            we      = 1'b1;
            rd      = 5'(x);
            data_in = sum;
            model[x] = model[x] + model[31 - x];
            @(negedge clk);
            we = 1'b0;
            #1;
            check($sformatf("writeback_x%0d", x), data_out1, model[x]);
            if (x == 1) check("writeback_example_r1", data_out1, 32'd33366701);
        end

        // ---------------- Hold with we=0 ----------------
        we = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            rd      = 5'(k + 3);
            data_in = 32'hA5A5_0000 + 32'(k);
        end
        @(negedge clk);
        for (int x = 0; x < 32; x++) begin
            rs1 = 5'(x);
            #1;
            check($sformatf("hold_x%0d", x), data_out1, model[x]);
        end

        // ---------------- Write timing on r5 ----------------
        @(negedge clk);
        rs1     = 5'd5;
        rs2     = 5'd5;
        we      = 1'b1;
        rd      = 5'd5;
        data_in = 32'hDEAD_BEEF;
        #1;
        check("r5_before_edge", data_out1, model[5]);
        @(posedge clk);
        #1;
        we = 1'b0;
        model[5] = 32'hDEAD_BEEF;
        check("r5_after_edge", data_out1, 32'hDEAD_BEEF);
        check("r5_same_idx_rd2", data_out2, 32'hDEAD_BEEF);

        // ---------------- Async reset mid-run ----------------
        @(negedge clk);
        rs1 = 5'd5;
        rs2 = 5'd31;
        #1;
        check("pre_reset_r31", data_out2, model[31]);
        #1;
        rstN = 1'b1;
        #1;
        check("async_reset_r5", data_out1, 32'd0);
        check("async_reset_r31", data_out2, 32'd0);
        // Hold reset across a clock edge with a write pending: reset wins.
        we      = 1'b1;
        rd      = 5'd7;
        data_in = 32'h1234_5678;
        @(posedge clk);
        #1;
        rs1 = 5'd7;
        #1;
        check("reset_dominates_write", data_out1, 32'd0);
        @(negedge clk);
        we   = 1'b0;
        rstN = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = '0;
        @(negedge clk);
        @(negedge clk);
        for (int x = 0; x < 32; x++) begin
            rs1 = 5'(x);
            #1;
            check($sformatf("post_reset_x%0d", x), data_out1, model[x]);
        end
        // Rewrite after reset works again.
        @(negedge clk);
        we      = 1'b1;
        rd      = 5'd9;
        data_in = 32'hFFFF_FFFF;
        @(negedge clk);
        we  = 1'b0;
        rs2 = 5'd9;
        #1;
        check("rewrite_after_reset_r9", data_out2, 32'hFFFF_FFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_register_file
`default_nettype wire
